delay_elastic: RTL and testbench

- Fixed-minimum-latency delay pipeline with valid/ready flow control.
- Companion to the per-bit delay line, on the downstream end: the plain delay line only pushes data forward, while this block also honours backpressure from its consumer.
- Holds up to DELAY words, preserves order and collapses bubbles.
- Sits between pipeline stages whose consumer can stall, e.g. a memory response path into writeback.

---
 rtl/delay_elastic_pkg.sv | 18 +
 rtl/delay_elastic_if.sv | 26 ++
 rtl/delay_elastic_stage.sv | 36 +++
 rtl/delay_elastic.sv | 96 +++++++++
 tb/tb_delay_elastic.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/delay_elastic_pkg.sv
// delay_elastic_pkg -- shared definitions for the elastic delay pipeline.
//   Data_Control_T : control bundle carrying clk and synchronous active-high rst.
//   DELAY_MIN      : smallest legal DELAY (stage count / capacity).
//   count_width()  : width of an occupancy counter for a given depth.
package delay_elastic_pkg;

    typedef struct packed {
        logic clk;
        logic rst;
    } Data_Control_T;

    localparam int unsigned DELAY_MIN = 1;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_elastic_if.sv
// delay_elastic_if -- valid/ready handshake bundle for delay_elastic.
//   flush                      : drop all held words on the next edge
//   in_valid/in_ready/in_data  : producer side
//   out_valid/out_ready/out_data : consumer side (out_data is the oldest word)
// Modports: slave = the pipeline, master = the surrounding logic driving it.
interface delay_elastic_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/delay_elastic_stage.sv
// delay_elastic_stage -- one valid+data register of the elastic pipeline.
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : clear the valid bit, data untouched
//   adv                   : this stage may take the upstream word this edge
//   prev_valid/prev_data  : upstream stage (or pipeline input)
//   valid/data            : registered stage contents
module delay_elastic_stage #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= prev_valid;
            // Data only loads with a real word; bubbles leave stale data behind.
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/delay_elastic.sv
// delay_elastic -- fixed-minimum-latency delay pipeline with valid/ready
// backpressure. Holds up to DELAY words in order and collapses bubbles.
//   ctrl  : Data_Control_T bundle (clk, synchronous active-high rst)
//   bus   : delay_elastic_if.slave (flush, in_* producer side, out_* consumer side)
//   count : (only with DELAY_ELASTIC_COUNT_EN defined) registered number of held words
// Parameters: WIDTH data width, DELAY stage count (min latency and capacity),
// RESET value of every data register after reset.
module delay_elastic
    import delay_elastic_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter int unsigned      DELAY = 2,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  Data_Control_T          ctrl,
    delay_elastic_if.slave         bus
`ifdef DELAY_ELASTIC_COUNT_EN
    ,
    output logic [count_width(DELAY)-1:0] count
`endif
);

    if (DELAY < DELAY_MIN) begin : g_delay_check
        $error("delay_elastic: DELAY must be at least %0d", DELAY_MIN);
    end

    logic clk;
    logic rst;
    assign clk = ctrl.clk;
    assign rst = ctrl.rst;

    logic [DELAY-1:0] v;
    logic [WIDTH-1:0] d [DELAY];
    logic [DELAY-1:0] adv;

    // A stage may advance when the stage after it advances or it is itself
    // empty; this lets words close up behind a stalled head.
    always_comb begin
        adv = '0;
        adv[DELAY-1] = bus.out_ready | ~v[DELAY-1];
        for (int unsigned k = 1; k < DELAY; k++) begin
            adv[DELAY-1-k] = adv[DELAY-k] | ~v[DELAY-1-k];
        end
    end

    for (genvar i = 0; i < DELAY; i++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_valid = bus.in_valid;
            assign prev_data  = bus.in_data;
        end else begin : g_body
            assign prev_valid = v[i-1];
            assign prev_data  = d[i-1];
        end

        delay_elastic_stage #(
            .WIDTH (WIDTH),
            .RESET (RESET)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (bus.flush),
            .adv        (adv[i]),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .valid      (v[i]),
            .data       (d[i])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = v[DELAY-1];
    assign bus.out_data  = d[DELAY-1];

`ifdef DELAY_ELASTIC_COUNT_EN
    localparam int unsigned CW = count_width(DELAY);

    logic in_xfer;
    logic out_xfer;
    assign in_xfer  = bus.in_valid & adv[0];
    assign out_xfer = v[DELAY-1] & bus.out_ready;

    // Bubble collapse never creates or destroys words, so occupancy moves
    // only by the two handshakes; this tracks popcount(v) without an adder tree.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end
`endif

endmodule

// File: tb/tb_delay_elastic.sv
// tb_delay_elastic -- self-checking bench for delay_elastic (DELAY=3, WIDTH=8,
// RESET=8'hEE). Accepted words are queued in a scoreboard and compared in
// order as the consumer takes them; directed sequences check latency,
// backpressure, bubble collapse, flush and mid-stream reset.
module tb_delay_elastic;
    import delay_elastic_pkg::*;

    localparam int unsigned      WIDTH = 8;
    localparam int unsigned      DELAY = 3;
    localparam logic [WIDTH-1:0] RSTV  = 8'hEE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    Data_Control_T ctrl;
    assign ctrl = '{clk: clk, rst: rst};

    always #5 clk = ~clk;

    delay_elastic_if #(.WIDTH(WIDTH)) bus ();

`ifdef DELAY_ELASTIC_COUNT_EN
    logic [count_width(DELAY)-1:0] count;
`endif

    delay_elastic #(
        .WIDTH (WIDTH),
        .DELAY (DELAY),
        .RESET (RSTV)
    ) dut (
        .ctrl  (ctrl),
        .bus   (bus)
`ifdef DELAY_ELASTIC_COUNT_EN
        ,
        .count (count)
`endif
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [WIDTH-1:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] id,
                         input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle once combinational paths settle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check("in_ready_model", 32'(bus.in_ready),
                  32'((sb.size() < int'(DELAY)) || bus.out_ready));
`ifdef DELAY_ELASTIC_COUNT_EN
            check("count_model", 32'(count), 32'(sb.size()));
`endif
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("out_valid_unexpected", 32'(bus.out_valid), 32'(0));
                end else begin
                    check("out_data_order", 32'(bus.out_data), 32'(sb.pop_front()));
                end
            end
            if (bus.flush) begin
                sb.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                sb.push_back(bus.in_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_data", 32'(bus.out_data), 32'(RSTV));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        tick();

        // Single word: latency DELAY
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_in_ready", 32'(bus.in_ready), 32'(1));
            check("t1_out_valid", 32'(bus.out_valid), 32'(k == 3));
            if (k == 3) check("t1_out_data", 32'(bus.out_data), 32'h11);
            tick();
            drive(1'b0, '0, 1'b1, 1'b0);
        end

        // Streaming 0x01..0x0A, no gaps
        for (int unsigned k = 0; k < 13; k++) begin
            drive(k < 10, 8'(k + 1), 1'b1, 1'b0);
            @(negedge clk);
            check("t2_out_valid", 32'(bus.out_valid), 32'(k >= 3));
            if (k >= 3) check("t2_out_data", 32'(bus.out_data), k - 2);
            tick();
        end

        // Fill under backpressure, then release with simultaneous in/out
        for (int unsigned k = 0; k < 4; k++) begin
            drive(1'b1, 8'(32'hA0 + k), 1'b0, 1'b0);
            @(negedge clk);
            check("t3_in_ready_fill", 32'(bus.in_ready), 32'(k < 3));
            tick();
        end
        for (int unsigned k = 0; k < 4; k++) begin
            drive(k == 0, 8'hA3, 1'b1, 1'b0);
            @(negedge clk);
            if (k == 0) check("t3_in_ready_release", 32'(bus.in_ready), 32'(1));
            check("t3_out_valid", 32'(bus.out_valid), 32'(1));
            check("t3_out_data", 32'(bus.out_data), 32'hA0 + k);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        check("t3_empty", 32'(bus.out_valid), 32'(0));
        tick();

        // Bubble collapse: B0, gap, B1 while stalled -> back-to-back on release
        drive(1'b1, 8'hB0, 1'b0, 1'b0); tick();
        drive(1'b0, '0,    1'b0, 1'b0); tick();
        drive(1'b1, 8'hB1, 1'b0, 1'b0); tick();
        drive(1'b0, '0,    1'b0, 1'b0);
        @(negedge clk);
        check("t4_head_valid", 32'(bus.out_valid), 32'(1));
        check("t4_head_data", 32'(bus.out_data), 32'hB0);
        tick();
        for (int unsigned k = 0; k < 2; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            @(negedge clk);
            check("t4_b2b_valid", 32'(bus.out_valid), 32'(1));
            check("t4_b2b_data", 32'(bus.out_data), 32'hB0 + k);
            tick();
        end

        // Flush with an offered word that must be dropped
        drive(1'b1, 8'hC0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hC1, 1'b0, 1'b0); tick();
        drive(1'b0, '0,    1'b0, 1'b0); tick();
        drive(1'b1, 8'h55, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_pre_valid", 32'(bus.out_valid), 32'(1));
        check("t5_pre_in_ready", 32'(bus.in_ready), 32'(1));
        tick();
        for (int unsigned k = 0; k < 5; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            @(negedge clk);
            check("t5_flushed_valid", 32'(bus.out_valid), 32'(0));
            check("t5_in_ready", 32'(bus.in_ready), 32'(1));
`ifdef DELAY_ELASTIC_COUNT_EN
            check("t5_count", 32'(count), 32'(0));
`endif
            tick();
        end

        // Reset mid-stream
        drive(1'b1, 8'hD0, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hD1, 1'b1, 1'b0); tick();
        rst = 1'b1;
        drive(1'b1, 8'hD2, 1'b1, 1'b0); tick();
        rst = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_out_valid", 32'(bus.out_valid), 32'(0));
            check("t6_out_data", 32'(bus.out_data), 32'(RSTV));
            check("t6_in_ready", 32'(bus.in_ready), 32'(1));
            tick();
        end

        // Random traffic with occasional flush, scoreboard-checked
        for (int unsigned k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
            tick();
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (DELAY + 2) tick();
        @(negedge clk);
        check("drain_out_valid", 32'(bus.out_valid), 32'(0));
        check("drain_sb_empty", 32'(sb.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
